// File: rtl/bsg_manycore_tq_pkg.sv
// Shared types and pointer helpers for the manycore tile-queue endpoints.
// Used by both the sender and the receiver halves.
package bsg_manycore_tq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } tq_sender_state_e;

    // True when a precedes b on a free-running w-bit pointer circle.
    function automatic logic tq_ptr_diff(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [63:0] d;
        d = a - b;
        return 1'(d >> (w - 1));
    endfunction

endpackage

// File: rtl/bsg_manycore_tq_update_slot.sv
// Single-entry coalescing valid/ready slot for send-pointer updates.
// The payload is the live pointer, so a newer value overwrites in place.
module bsg_manycore_tq_update_slot
    import bsg_manycore_tq_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               set_i,
    input  logic [width_p-1:0] data_i,
    input  logic               ready_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    tq_sender_state_e state_q;
    tq_sender_state_e state_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A set on the handshake edge keeps the slot full for the newer value.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (set_i) state_d = PEND;
            PEND: if (ready_i && !set_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign v_o    = (state_q == PEND);
    assign data_o = data_i;

endmodule

// File: rtl/bsg_manycore_tq_sender.sv
// Producer side of a tile queue: send/recv pointers, room check,
// protocol error flag and coalesced send-pointer updates.
module bsg_manycore_tq_sender
    import bsg_manycore_tq_pkg::*;
#(
    parameter int width_p          = 32,
    parameter int capacity_p       = 4,
    parameter int max_depth_p      = 1,
    parameter int lg_max_depth_p   = $clog2(max_depth_p + 1),
    parameter bit assert_illegal_p = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [lg_max_depth_p-1:0] depth_i,
    output logic                      confirm_o,
    input  logic                      release_i,
    input  logic                      recv_v_i,
    input  logic [width_p-1:0]        recv_data_i,
    output logic                      send_v_o,
    output logic [width_p-1:0]        send_data_o,
    input  logic                      send_ready_i,
    output logic                      error_o
);

    logic [width_p-1:0] send_q, send_d;
    logic [width_p-1:0] recv_q, recv_d;
    logic               error_q, error_d;
    logic [width_p-1:0] depth_ext;
    logic [width_p-1:0] room_lhs;
    logic [width_p-1:0] room_rhs;
    logic               accept;
    logic               illegal;
    logic               recv_bad;
    logic               slot_set;

    always_comb begin
        depth_ext = width_p'(depth_i);
        room_lhs  = send_q + depth_ext;
        room_rhs  = recv_q + width_p'(capacity_p + 1);
        // Room exists while send+depth stays behind recv+capacity+1.
        confirm_o = tq_ptr_diff(64'(room_lhs), 64'(room_rhs), width_p);
        accept    = release_i & confirm_o;
        illegal   = release_i & ~confirm_o;
        recv_bad  = recv_v_i
                  & tq_ptr_diff(64'(send_q), 64'(recv_data_i), width_p);
        slot_set  = accept & (depth_i != '0);
        send_d    = accept ? room_lhs : send_q;
        recv_d    = recv_v_i ? recv_data_i : recv_q;
        error_d   = error_q | illegal | recv_bad;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            send_q  <= '0;
            recv_q  <= '0;
            error_q <= 1'b0;
        end else begin
            send_q  <= send_d;
            recv_q  <= recv_d;
            error_q <= error_d;
        end
    end

    bsg_manycore_tq_update_slot #(
        .width_p (width_p)
    ) u_slot (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .set_i     (slot_set),
        .data_i    (send_q),
        .ready_i   (send_ready_i),
        .v_o       (send_v_o),
        .data_o    (send_data_o)
    );

    assign error_o = error_q;

    if (assert_illegal_p) begin : g_release_chk
        always_ff @(posedge clk_i) begin
            assert (!(reset_n_i && illegal))
            else $error("tq_sender: release without confirm");
        end
    end

endmodule

// File: tb/tb_bsg_manycore_tq_sender.sv
// Directed and random checks of the tile-queue sender against an
// occupancy-based model; a narrow instance covers pointer wrap.
module tb_bsg_manycore_tq_sender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rel_a = 1'b0;
    logic [2:0]  dep_a = '0;
    logic        rv_a = 1'b0;
    logic [31:0] rd_a = '0;
    logic        rdy_a = 1'b0;
    logic        conf_a, sv_a, err_a;
    logic [31:0] sd_a;

    logic        rel_b = 1'b0;
    logic [0:0]  dep_b = '0;
    logic        rv_b = 1'b0;
    logic [3:0]  rd_b = '0;
    logic        rdy_b = 1'b0;
    logic        conf_b, sv_b, err_b;
    logic [3:0]  sd_b;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_send = '0;
    logic [31:0] m_recv = '0;
    bit          m_pend = 1'b0;
    bit          m_err = 1'b0;
    int          hs_cnt = 0;
    logic [31:0] hs_last = '0;

    always #5 clk = ~clk;

    bsg_manycore_tq_sender #(
        .width_p          (32),
        .capacity_p       (4),
        .max_depth_p      (4),
        .lg_max_depth_p   (3),
        .assert_illegal_p (1'b0)
    ) dut_a (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .depth_i      (dep_a),
        .confirm_o    (conf_a),
        .release_i    (rel_a),
        .recv_v_i     (rv_a),
        .recv_data_i  (rd_a),
        .send_v_o     (sv_a),
        .send_data_o  (sd_a),
        .send_ready_i (rdy_a),
        .error_o      (err_a)
    );

    bsg_manycore_tq_sender #(
        .width_p          (4),
        .capacity_p       (4),
        .max_depth_p      (1),
        .lg_max_depth_p   (1),
        .assert_illegal_p (1'b0)
    ) dut_b (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .depth_i      (dep_b),
        .confirm_o    (conf_b),
        .release_i    (rel_b),
        .recv_v_i     (rv_b),
        .recv_data_i  (rd_b),
        .send_v_o     (sv_b),
        .send_data_o  (sd_b),
        .send_ready_i (rdy_b),
        .error_o      (err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Room exists when occupancy after the write is within capacity.
    function automatic bit model_conf(input logic [2:0] dep);
        int occ;
        occ = int'(m_send - m_recv) + int'(dep);
        return occ <= 4;
    endfunction

    task automatic model_clear();
        m_send = '0;
        m_recv = '0;
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic step_a(input logic rel, input logic [2:0] dep,
                          input logic rv, input logic [31:0] rd,
                          input logic rdy);
        bit conf;
        rel_a = rel;
        dep_a = dep;
        rv_a  = rv;
        rd_a  = rd;
        rdy_a = rdy;
        #1;
        conf = model_conf(dep);
        chk("confirm", 32'(conf_a), 32'(conf));
        chk("send_v", 32'(sv_a), 32'(m_pend));
        chk("send_data", sd_a, m_send);
        chk("error", 32'(err_a), 32'(m_err));
        if (sv_a && rdy) begin
            hs_cnt++;
            hs_last = sd_a;
        end
        @(posedge clk);
        if (rel && !conf) m_err = 1'b1;
        if (rv) begin
            if (int'(m_send - rd) < 0) m_err = 1'b1;
            m_recv = rd;
        end
        if (rel && conf && dep != 0) m_pend = 1'b1;
        else if (m_pend && rdy) m_pend = 1'b0;
        if (rel && conf) m_send = m_send + 32'(dep);
        #1;
        rel_a = 1'b0;
        rv_a  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic step_b(input logic rel, input logic rv,
                          input logic [3:0] rd);
        rel_b = rel;
        dep_b = 1'b1;
        rv_b  = rv;
        rd_b  = rd;
        rdy_b = 1'b1;
        @(posedge clk);
        #1;
        rel_b = 1'b0;
        rv_b  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  bs;
        logic [2:0]  dep;
        logic        rel;
        logic        rv;
        logic [31:0] rd;

        do_reset();
        dep_a = 3'd4;
        #1;
        chk("rst_confirm_d4", 32'(conf_a), 32'd1);
        chk("rst_send_v", 32'(sv_a), 32'd0);
        chk("rst_send_data", sd_a, 32'd0);
        chk("rst_error", 32'(err_a), 32'd0);

        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, 3'd1, 1'b0, '0, 1'b1);
            chk("fill_data", sd_a, 32'(i + 1));
        end
        dep_a = 3'd1;
        #1;
        chk("full_conf_d1", 32'(conf_a), 32'd0);
        step_a(1'b0, 3'd0, 1'b1, 32'd2, 1'b1);
        dep_a = 3'd1;
        #1;
        chk("drain_conf_d1", 32'(conf_a), 32'd1);
        dep_a = 3'd2;
        #1;
        chk("drain_conf_d2", 32'(conf_a), 32'd1);
        dep_a = 3'd3;
        #1;
        chk("drain_conf_d3", 32'(conf_a), 32'd0);
        step_a(1'b0, 3'd0, 1'b1, 32'd4, 1'b1);
        step_a(1'b0, 3'd0, 1'b0, '0, 1'b1);

        hs_cnt = 0;
        for (int i = 0; i < 3; i++) step_a(1'b1, 3'd1, 1'b0, '0, 1'b0);
        chk("coal_v", 32'(sv_a), 32'd1);
        chk("coal_data", sd_a, 32'd7);
        step_a(1'b0, 3'd0, 1'b0, '0, 1'b1);
        chk("coal_v_after", 32'(sv_a), 32'd0);
        chk("coal_hs_cnt", 32'(hs_cnt), 32'd1);
        chk("coal_hs_val", hs_last, 32'd7);
        step_a(1'b0, 3'd0, 1'b0, '0, 1'b1);
        chk("coal_hs_once", 32'(hs_cnt), 32'd1);

        step_a(1'b0, 3'd0, 1'b1, 32'd7, 1'b0);
        step_a(1'b1, 3'd1, 1'b0, '0, 1'b0);
        step_a(1'b1, 3'd1, 1'b0, '0, 1'b1);
        chk("simul_v", 32'(sv_a), 32'd1);
        chk("simul_data", sd_a, 32'd9);
        chk("simul_hs_val", hs_last, 32'd8);
        step_a(1'b0, 3'd0, 1'b0, '0, 1'b1);
        chk("simul_hs_last", hs_last, 32'd9);

        do_reset();
        step_a(1'b1, 3'd4, 1'b0, '0, 1'b1);
        step_a(1'b1, 3'd1, 1'b0, '0, 1'b1);
        chk("illegal_data", sd_a, 32'd4);
        chk("illegal_err", 32'(err_a), 32'd1);

        do_reset();
        for (int i = 0; i < 3; i++) step_a(1'b1, 3'd1, 1'b0, '0, 1'b1);
        step_a(1'b0, 3'd0, 1'b1, 32'd5, 1'b1);
        chk("recv_ahead_err", 32'(err_a), 32'd1);

        do_reset();
        step_a(1'b1, 3'd2, 1'b0, '0, 1'b0);
        chk("pre_rst_v", 32'(sv_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        dep_a = 3'd4;
        #1;
        chk("async_rst_v", 32'(sv_a), 32'd0);
        chk("async_rst_data", sd_a, 32'd0);
        chk("async_rst_err", 32'(err_a), 32'd0);
        chk("async_rst_conf", 32'(conf_a), 32'd1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 400; i++) begin
            dep = 3'($urandom_range(0, 4));
            rel = model_conf(dep) && ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 3) == 0);
            rd  = m_recv + $urandom_range(0, m_send - m_recv);
            step_a(rel, dep, rv, rd, 1'($urandom_range(0, 1)));
        end
        chk("rand_no_err", 32'(err_a), 32'd0);

        bs = '0;
        for (int i = 0; i < 14; i++) begin
            step_b(1'b1, 1'b1, bs);
            bs = bs + 4'd1;
        end
        step_b(1'b0, 1'b1, bs);
        chk("wrap_pre_send", 32'(sd_b), 32'hE);
        for (int i = 0; i < 4; i++) begin
            dep_b = 1'b1;
            #1;
            chk("wrap_conf", 32'(conf_b), 32'd1);
            step_b(1'b1, 1'b0, '0);
        end
        chk("wrap_send", 32'(sd_b), 32'h2);
        chk("wrap_full", 32'(conf_b), 32'd0);
        chk("wrap_err", 32'(err_b), 32'd0);
        chk("wrap_send_v", 32'(sv_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_tq_sender.md
# bsg_manycore_tq_sender

Producer-side half of a hardware tile queue, and the peer that feeds `bsg_tq_receiver`. It holds the local send pointer and a shadow copy of the remote receive pointer, and confirms when there is room for `depth_i` more elements. On release it advances the send pointer and emits a coalescing pointer-update message over a valid/ready link toward the remote receiver's send register. Remote receive-pointer updates arrive from the network and replenish space.

## Interface
- `width_p`, 32, pointer width; free-running pointers wrap modulo 2^`width_p`.
- `capacity_p`, 4, queue capacity in elements; must be less than 2^(`width_p`-1).
- `max_depth_p`, 1, largest element count per confirm/release.
- `lg_max_depth_p`, `BSG_CLOG2_SAFE(max_depth_p+1)`, width of `depth_i`.

Ports. One clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous active-low reset.
- `depth_i` in `lg_max_depth_p`: elements requested.
- `confirm_o` out 1: room exists for `depth_i` elements.
- `release_i` in 1: commit `depth_i` elements; legal only while `confirm_o` is high.
- `recv_v_i` in 1: remote receive-pointer update valid.
- `recv_data_i` in `width_p`: new remote receive pointer.
- `send_v_o` out 1: send-pointer update pending.
- `send_data_o` out `width_p`: current send pointer.
- `send_ready_i` in 1: link accepts the update.
- `error_o` out 1: sticky protocol-violation flag.

## Operation
- State:
  - `send_r`, the send pointer.
  - `recv_r`, the shadow receive pointer.
  - FSM `IDLE`/`PEND`.
  - `error_r`.
- Confirm arithmetic, all modulo 2^`width_p`:
  - `diff = send_r + depth_i - recv_r - capacity_p - 1`.
  - `confirm_o = diff[width_p-1]`, which means occupancy after the write is at most `capacity_p`.
- Accepted release (`release_i & confirm_o`):
  - `send_r <= send_r + depth_i`.
  - If `depth_i != 0`, the FSM goes to `PEND`.
  - A zero-depth release changes nothing.
- Illegal release (`release_i & ~confirm_o`):
  - Ignored; no pointer or FSM change.
  - Sets `error_r`; the simulation assertion fires `$error`.
- `recv_v_i`:
  - `recv_r <= recv_data_i`.
  - If the new value exceeds `send_r`, i.e. `(send_r - recv_data_i)` has its sign bit set, set `error_r`; the value is still loaded.
- FSM:
  - `IDLE` to `PEND` on an accepted release with nonzero depth.
  - `PEND` to `IDLE` when `send_ready_i` is high and there is no accepted nonzero release in the same cycle.
  - `PEND` stays in `PEND` on a handshake with a simultaneous release; the new value goes out next.
- `send_v_o = (state == PEND)`. `send_data_o = send_r`.
- Coalescing: while `send_v_o` is high, `send_data_o` may advance on further releases. This is a deliberate relaxation of data stability: pointers are monotonic, so the consumer needs only the latest value. Exactly one message is pending at most.
- `recv_v_i` and release in the same cycle are independent; both apply.

## Timing
- Reset values:
  - `send_r = 0`, `recv_r = 0`, state `IDLE`.
  - `send_v_o = 0`, `send_data_o = 0`, `error_o = 0`.
  - `confirm_o = (depth_i <= capacity_p)`.
- `confirm_o` is combinational from `depth_i`, `send_r` and `recv_r`. A release or a `recv_v_i` affects it from the next cycle.
- `send_v_o` rises one cycle after an accepted release.
- A handshake happens on the rising edge where `send_v_o & send_ready_i`.
- Back-to-back releases with `send_ready_i` held high: one update per cycle, each carrying the latest pointer.
- Asserting reset mid-update drops the pending message immediately, asynchronously; `send_v_o` falls without a handshake.
- Pointer wrap at 2^`width_p`: the signed-difference compare remains correct.

## Structure
- Package `bsg_manycore_tq_pkg`:
  - `tq_sender_state_e` {`IDLE`, `PEND`}.
  - Shared pointer-difference helper function `tq_ptr_diff`, reused by the receiver side.
- Sub-module `bsg_manycore_tq_update_slot`: a single-entry coalescing valid/ready slot (set, handshake, overwrite). The top level contains the pointer registers, confirm logic and error checks.
- Registers use async-low-reset flops. The reset-sensitive `always_ff` is on `posedge clk_i or negedge reset_n_i`.

## Test plan
- Fill and drain:
  - Four releases of depth 1 with `send_ready_i=1` produce `send_data_o` 1, 2, 3, 4.
  - Then `confirm_o=0` for depth 1.
  - `recv_v_i` with data 2 makes `confirm_o=1` the next cycle, for depth 1 and depth 2.
- Coalescing:
  - With `send_ready_i=0`, three depth-1 releases leave `send_v_o=1` and `send_data_o=3`.
  - Raising ready gives exactly one handshake with value 3, then `send_v_o=0`.
- Simultaneous handshake and release: handshake at value 1 plus a release in the same cycle gives `send_v_o` still 1 and `send_data_o=2` next cycle.
- Wrap: preload `send_r=recv_r=32'hFFFF_FFFE` via releases and recv updates; four depth-1 releases give `send_data_o=32'h0000_0002`, `confirm_o=0`, `error_o=0`.
- Violations:
  - A release while `confirm_o=0` leaves pointers unchanged and raises `error_o`.
  - `recv_data_i=5` with `send_r=3` also raises `error_o`.
- Reset mid-operation: deassert `reset_n_i` while `send_v_o=1`, asynchronously between edges; all outputs return to reset values before the next clock edge.
